// File: rtl/omsp_uart_tx_if.sv
// Peripheral bus bundle between the openMSP430 core and this UART transmitter.
interface omsp_uart_tx_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (
    output per_addr,
    output per_din,
    output per_en,
    output per_we,
    input  per_dout
  );

  modport slave (
    input  per_addr,
    input  per_din,
    input  per_en,
    input  per_we,
    output per_dout
  );
endinterface

// File: rtl/omsp_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the openMSP430 peripheral bus.
module omsp_uart_tx #(
  parameter logic [14:0] BASE_ADDR    = 15'h0080,
  parameter logic [15:0] DEFAULT_BAUD = 16'd433,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic            mclk,
  input  logic            puc_rst,
  omsp_uart_tx_if.slave   per,
  output logic            uart_txd,
  output logic            irq_tx
);

  localparam int unsigned FIFO_DEPTH = 2 ** FIFO_AW;
  localparam int unsigned LVL_W      = FIFO_AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic               tx_en;
  logic               irq_en;
  logic [15:0]        baud;
  logic               done;
  logic               ovf;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               full;
  logic               empty;
  logic [7:0]         fifo_head;

  logic [15:0]        bit_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic [7:0]         shift_nxt;
  logic               txd_nxt;
  logic               tick;
  logic               pop;
  logic               shift_en;
  logic               done_set;

  logic               sel;
  logic [1:0]         reg_idx;
  logic               wr_lo;
  logic               wr_hi;
  logic               rd;
  logic               push;
  logic               push_ok;
  logic               push_rej;
  logic               stat_wr;
  logic [7:0]         status;

  assign sel      = per.per_en && (per.per_addr[13:2] == BASE_ADDR[14:3]);
  assign reg_idx  = per.per_addr[1:0];
  assign wr_lo    = sel && per.per_we[0];
  assign wr_hi    = sel && per.per_we[1];
  assign rd       = sel && (per.per_we == 2'b00);
  assign push     = wr_lo && (reg_idx == 2'd3);
  assign push_ok  = push && !full;
  assign push_rej = push && full;
  assign stat_wr  = wr_lo && (reg_idx == 2'd1);

  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign fifo_head = mem[rd_ptr];
  assign tick      = (bit_cnt >= baud);

  assign status = {3'(level), ovf, done, empty, full, (state != IDLE)};

  // Combinational register read mux; silent unless selected for a read.
  always_comb begin
    per.per_dout = '0;
    if (rd) begin
      case (reg_idx)
        2'd0:    per.per_dout = {14'b0, irq_en, tx_en};
        2'd1:    per.per_dout = {8'b0, status};
        2'd2:    per.per_dout = baud;
        default: per.per_dout = '0;
      endcase
    end
  end

  // Control, baud and sticky status flags; a set in the same cycle beats a clear.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      tx_en  <= 1'b0;
      irq_en <= 1'b0;
      baud   <= DEFAULT_BAUD;
      done   <= 1'b0;
      ovf    <= 1'b0;
      irq_tx <= 1'b0;
    end else begin
      if (wr_lo && (reg_idx == 2'd0)) begin
        tx_en  <= per.per_din[0];
        irq_en <= per.per_din[1];
      end
      if (wr_lo && (reg_idx == 2'd2)) baud[7:0]  <= per.per_din[7:0];
      if (wr_hi && (reg_idx == 2'd2)) baud[15:8] <= per.per_din[15:8];
      if (done_set)                          done <= 1'b1;
      else if (stat_wr && per.per_din[3])    done <= 1'b0;
      if (push_rej)                          ovf  <= 1'b1;
      else if (stat_wr && per.per_din[4])    ovf  <= 1'b0;
      irq_tx <= done && irq_en;
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge mclk) begin
    if (push_ok) mem[wr_ptr] <= per.per_din[7:0];
  end

  // FIFO pointers and fill level; a same-cycle pop never frees room for the push.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      level <= level + LVL_W'(push_ok) - LVL_W'(pop);
    end
  end

  // State register.
  always_ff @(posedge mclk) begin
    if (puc_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: bit sequencing and FIFO pops.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    shift_en  = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en && !empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 shift_en  = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (tx_en && !empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
            done_set  = empty;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next shift contents and the line level for the upcoming state.
  always_comb begin
    shift_nxt = shift;
    if (pop)           shift_nxt = fifo_head;
    else if (shift_en) shift_nxt = {1'b0, shift[7:1]};
    txd_nxt = 1'b1;
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  // Bit timer, bit index, shift register and registered serial output.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_txd <= 1'b1;
    end else begin
      shift    <= shift_nxt;
      uart_txd <= txd_nxt;
      if ((state == IDLE) || tick) bit_cnt <= '0;
      else                         bit_cnt <= bit_cnt + 16'd1;
      if (state != DATA) bit_idx <= '0;
      else if (tick)     bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule
